// File: rtl/fpu_ss_pkg.sv
// fpu_ss_pkg
// Shared types for the eXtension-interface initiator of the FPU subsystem:
// issue request, commit, memory request and result payloads, plus the
// default size of the instruction ID space.
package fpu_ss_pkg;

    localparam int NUM_ID_DEFAULT = 16;
    localparam int ID_W           = $clog2(NUM_ID_DEFAULT);

    typedef logic [ID_W-1:0] id_t;

    typedef struct packed {
        logic [31:0]       instr;
        id_t               id;
        logic [2:0][31:0]  rs;
        logic [2:0]        rs_valid;
    } x_issue_req_t;

    typedef struct packed {
        id_t  id;
        logic commit_kill;
    } x_commit_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } x_mem_req_t;

    typedef struct packed {
        id_t         id;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } x_result_t;

    // Sequential ID generator; wraps at the top of the ID space.
    function automatic id_t id_incr(id_t id, int num_id);
        id_incr = (id == id_t'(num_id - 1)) ? '0 : id + 1'b1;
    endfunction

endpackage

// File: rtl/fpu_ss_xif_mem_resp.sv
// fpu_ss_xif_mem_resp
// Maps coprocessor memory requests onto an OBI-style data port, limits the
// number of granted-but-unanswered transactions and registers each response
// back to the coprocessor in order.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   mem_valid_i / mem_ready_o      coprocessor memory request handshake
//   mem_req_i                      request payload {id, addr, we, wdata}
//   result_valid_o, result_rdata_o registered memory result (1 cycle after rvalid)
//   data_req_o / data_gnt_i        data port request / grant
//   data_addr_o, data_we_o,
//   data_wdata_o                   data port request fields (pass-through)
//   data_rvalid_i, data_rdata_i    data port response
//   busy_o                         transactions in flight
//   err_o                          response seen with nothing outstanding (pulse)
module fpu_ss_xif_mem_resp
    import fpu_ss_pkg::*;
#(
    parameter int MEM_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_valid_i,
    output logic        mem_ready_o,
    input  x_mem_req_t  mem_req_i,
    output logic        result_valid_o,
    output logic [31:0] result_rdata_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        busy_o,
    output logic        err_o
);

    localparam int CNT_W = $clog2(MEM_OUTSTANDING + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             space;
    logic             grant;
    logic             cnt_zero;
    logic             unused_mem_id;

    assign space    = cnt_q < CNT_W'(MEM_OUTSTANDING);
    assign cnt_zero = cnt_q == '0;

    assign data_req_o   = mem_valid_i & space;
    assign mem_ready_o  = data_gnt_i & space;
    assign data_addr_o  = mem_req_i.addr;
    assign data_we_o    = mem_req_i.we;
    assign data_wdata_o = mem_req_i.wdata;
    assign grant        = data_req_o & data_gnt_i;

    assign busy_o = ~cnt_zero;
    assign err_o  = data_rvalid_i & cnt_zero;

    // The data port answers in order, so the request ID is not needed here.
    assign unused_mem_id = ^mem_req_i.id;

    // A grant and a response in the same cycle cancel; a stray response
    // never drives the counter below zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (grant && !data_rvalid_i) begin
            cnt_q <= cnt_q + 1'b1;
        end else if (!grant && data_rvalid_i && !cnt_zero) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_valid_o <= 1'b0;
            result_rdata_o <= '0;
        end else begin
            result_valid_o <= data_rvalid_i;
            if (data_rvalid_i) begin
                result_rdata_o <= data_rdata_i;
            end
        end
    end

endmodule

// File: rtl/fpu_ss_xif_initiator.sv
// fpu_ss_xif_initiator
// Core-side eXtension-interface initiator for the FPU subsystem. Issues core
// instructions with sequential IDs, emits one commit per issue, services
// coprocessor memory requests on the data port and returns results to the
// register file through a single-entry writeback register.
// Build option: define FPU_SS_XIF_KILL_EN to honour kill_i; otherwise kill_i
// is ignored and commit_kill reflects only a rejected issue.
// Ports:
//   clk_i, rst_ni                          clock, async active-low reset
//   instr_valid_i/instr_ready_o, instr_i,
//   rs_i, rs_valid_i, kill_i               core instruction side
//   x_issue_*                              XIF issue channel
//   x_commit_valid_o, x_commit_o           XIF commit channel
//   x_mem_*                                XIF memory request / result
//   data_*                                 OBI-style data port
//   x_result_*                             XIF result channel
//   wb_valid_o/wb_ready_i, wb_rd_o,
//   wb_data_o                              register file writeback
//   busy_o, protocol_err_o                 status
module fpu_ss_xif_initiator
    import fpu_ss_pkg::*;
#(
    parameter int NUM_ID          = NUM_ID_DEFAULT,
    parameter int MEM_OUTSTANDING = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_valid_i,
    output logic             instr_ready_o,
    input  logic [31:0]      instr_i,
    input  logic [2:0][31:0] rs_i,
    input  logic [2:0]       rs_valid_i,
    input  logic             kill_i,
    output logic             x_issue_valid_o,
    input  logic             x_issue_ready_i,
    output x_issue_req_t     x_issue_req_o,
    input  logic             x_issue_resp_accept_i,
    input  logic             x_issue_resp_writeback_i,
    output logic             x_commit_valid_o,
    output x_commit_t        x_commit_o,
    input  logic             x_mem_valid_i,
    output logic             x_mem_ready_o,
    input  x_mem_req_t       x_mem_req_i,
    output logic             x_mem_result_valid_o,
    output logic [31:0]      x_mem_result_rdata_o,
    output logic             data_req_o,
    input  logic             data_gnt_i,
    output logic [31:0]      data_addr_o,
    output logic [31:0]      data_wdata_o,
    output logic             data_we_o,
    input  logic             data_rvalid_i,
    input  logic [31:0]      data_rdata_i,
    input  logic             x_result_valid_i,
    output logic             x_result_ready_o,
    input  x_result_t        x_result_i,
    output logic             wb_valid_o,
    input  logic             wb_ready_i,
    output logic [4:0]       wb_rd_o,
    output logic [31:0]      wb_data_o,
    output logic             busy_o,
    output logic             protocol_err_o
);

    logic [NUM_ID-1:0] outstanding_q, outstanding_d;
    id_t               next_id_q;
    logic              issue_hs;
    logic              kill_eff;
    logic              set_out;
    logic              res_hs;
    logic              res_known;
    logic              mem_busy;
    logic              mem_err;

`ifdef FPU_SS_XIF_KILL_EN
    assign kill_eff = kill_i;
`else
    logic unused_kill;
    assign kill_eff    = 1'b0;
    assign unused_kill = kill_i;
`endif

    assign x_issue_valid_o = instr_valid_i & ~outstanding_q[next_id_q];
    assign instr_ready_o   = x_issue_valid_o & x_issue_ready_i;
    assign issue_hs        = instr_ready_o;
    assign x_issue_req_o   = '{instr: instr_i, id: next_id_q, rs: rs_i, rs_valid: rs_valid_i};

    assign set_out = issue_hs & x_issue_resp_accept_i & x_issue_resp_writeback_i & ~kill_eff;

    assign x_result_ready_o = ~wb_valid_o | wb_ready_i;
    assign res_hs           = x_result_valid_i & x_result_ready_o;
    assign res_known        = outstanding_q[x_result_i.id];

    // Clear before set: a stray result that happens to name next_id must not
    // cancel an instruction issued in the same cycle.
    always_comb begin
        outstanding_d = outstanding_q;
        if (res_hs) begin
            outstanding_d[x_result_i.id] = 1'b0;
        end
        if (set_out) begin
            outstanding_d[next_id_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
            next_id_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            if (issue_hs) begin
                next_id_q <= id_incr(next_id_q, NUM_ID);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_commit_valid_o <= 1'b0;
            x_commit_o       <= '0;
        end else begin
            x_commit_valid_o <= issue_hs;
            if (issue_hs) begin
                x_commit_o <= '{id: next_id_q, commit_kill: ~x_issue_resp_accept_i | kill_eff};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
        end else if (res_hs && res_known && x_result_i.we) begin
            wb_valid_o <= 1'b1;
            wb_rd_o    <= x_result_i.rd;
            wb_data_o  <= x_result_i.data;
        end else if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            protocol_err_o <= 1'b0;
        end else if ((res_hs && !res_known) || mem_err) begin
            protocol_err_o <= 1'b1;
        end
    end

    fpu_ss_xif_mem_resp #(
        .MEM_OUTSTANDING(MEM_OUTSTANDING)
    ) u_mem_resp (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .mem_valid_i    (x_mem_valid_i),
        .mem_ready_o    (x_mem_ready_o),
        .mem_req_i      (x_mem_req_i),
        .result_valid_o (x_mem_result_valid_o),
        .result_rdata_o (x_mem_result_rdata_o),
        .data_req_o     (data_req_o),
        .data_gnt_i     (data_gnt_i),
        .data_addr_o    (data_addr_o),
        .data_we_o      (data_we_o),
        .data_wdata_o   (data_wdata_o),
        .data_rvalid_i  (data_rvalid_i),
        .data_rdata_i   (data_rdata_i),
        .busy_o         (mem_busy),
        .err_o          (mem_err)
    );

    assign busy_o = (|outstanding_q) | x_commit_valid_o | mem_busy | wb_valid_o;

endmodule

// File: tb/tb_fpu_ss_xif_initiator.sv
// Directed bench for fpu_ss_xif_initiator: table-driven issue/commit vectors
// plus hand-written sequences for ID wrap stall, memory flow control,
// writeback back-pressure and the sticky protocol error.
module tb_fpu_ss_xif_initiator;
    import fpu_ss_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             instr_valid_i, instr_ready_o;
    logic [31:0]      instr_i;
    logic [2:0][31:0] rs_i;
    logic [2:0]       rs_valid_i;
    logic             kill_i;
    logic             x_issue_valid_o, x_issue_ready_i;
    x_issue_req_t     x_issue_req_o;
    logic             x_issue_resp_accept_i, x_issue_resp_writeback_i;
    logic             x_commit_valid_o;
    x_commit_t        x_commit_o;
    logic             x_mem_valid_i, x_mem_ready_o;
    x_mem_req_t       x_mem_req_i;
    logic             x_mem_result_valid_o;
    logic [31:0]      x_mem_result_rdata_o;
    logic             data_req_o, data_gnt_i;
    logic [31:0]      data_addr_o, data_wdata_o;
    logic             data_we_o, data_rvalid_i;
    logic [31:0]      data_rdata_i;
    logic             x_result_valid_i, x_result_ready_o;
    x_result_t        x_result_i;
    logic             wb_valid_o, wb_ready_i;
    logic [4:0]       wb_rd_o;
    logic [31:0]      wb_data_o;
    logic             busy_o, protocol_err_o;

    fpu_ss_xif_initiator dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_i(instr_i), .rs_i(rs_i), .rs_valid_i(rs_valid_i), .kill_i(kill_i),
        .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
        .x_issue_req_o(x_issue_req_o),
        .x_issue_resp_accept_i(x_issue_resp_accept_i),
        .x_issue_resp_writeback_i(x_issue_resp_writeback_i),
        .x_commit_valid_o(x_commit_valid_o), .x_commit_o(x_commit_o),
        .x_mem_valid_i(x_mem_valid_i), .x_mem_ready_o(x_mem_ready_o),
        .x_mem_req_i(x_mem_req_i),
        .x_mem_result_valid_o(x_mem_result_valid_o),
        .x_mem_result_rdata_o(x_mem_result_rdata_o),
        .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_we_o(data_we_o), .data_rvalid_i(data_rvalid_i),
        .data_rdata_i(data_rdata_i),
        .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
        .x_result_i(x_result_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
        .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .protocol_err_o(protocol_err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [31:0] instr;
        logic        acc;
        logic        wb;
        logic        kill;
        logic [3:0]  id;
        logic        ckill;
        logic [15:0] outst;
    } iss_vec_t;

    iss_vec_t iv [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        instr_valid_i = 0; instr_i = '0; rs_i = '0; rs_valid_i = '0; kill_i = 0;
        x_issue_ready_i = 1; x_issue_resp_accept_i = 0; x_issue_resp_writeback_i = 0;
        x_mem_valid_i = 0; x_mem_req_i = '0; data_gnt_i = 0; data_rvalid_i = 0;
        data_rdata_i = '0; x_result_valid_i = 0; x_result_i = '0; wb_ready_i = 0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        idle();
        #7;
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
    endtask

    task automatic drive_issue(input logic [31:0] instr, input logic acc, input logic wb, input logic kill);
        instr_valid_i = 1; x_issue_ready_i = 1; instr_i = instr;
        rs_i[1] = instr ^ 32'h5a5a_0000; rs_valid_i = 3'b011;
        x_issue_resp_accept_i = acc; x_issue_resp_writeback_i = wb; kill_i = kill;
    endtask

    task automatic check_commit(input iss_vec_t v);
        check("commit_valid", x_commit_valid_o, 1);
        check("commit_id", x_commit_o.id, v.id);
        check("commit_kill", x_commit_o.commit_kill, v.ckill);
        check("outstanding", dut.outstanding_q, v.outst);
    endtask

    initial begin
        iv[0] = '{32'h0020_F053, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 16'h0001};
        iv[1] = '{32'h0041_F0D3, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0, 16'h0003};
        iv[2] = '{32'h0062_F153, 1'b1, 1'b1, 1'b0, 4'd2, 1'b0, 16'h0007};
        iv[3] = '{32'h0000_0013, 1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 16'h0007};
        iv[4] = '{32'hA020_8053, 1'b1, 1'b0, 1'b0, 4'd4, 1'b0, 16'h0007};
`ifdef FPU_SS_XIF_KILL_EN
        iv[5] = '{32'h0083_F1D3, 1'b1, 1'b1, 1'b1, 4'd5, 1'b1, 16'h0007};
`else
        iv[5] = '{32'h0083_F1D3, 1'b1, 1'b1, 1'b1, 4'd5, 1'b0, 16'h0027};
`endif

        // Reset state
        do_reset();
        settle();
        check("rst_commit_valid", x_commit_valid_o, 0);
        check("rst_commit", x_commit_o, 0);
        check("rst_wb_valid", wb_valid_o, 0);
        check("rst_wb_data", wb_data_o, 0);
        check("rst_memres_valid", x_mem_result_valid_o, 0);
        check("rst_memres_rdata", x_mem_result_rdata_o, 0);
        check("rst_err", protocol_err_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_next_id", x_issue_req_o.id, 0);
        check("rst_instr_ready", instr_ready_o, 0);

        // Back-to-back issue vectors
        for (int i = 0; i < 6; i++) begin
            drive_issue(iv[i].instr, iv[i].acc, iv[i].wb, iv[i].kill);
            settle();
            check("issue_valid", x_issue_valid_o, 1);
            check("instr_ready", instr_ready_o, 1);
            check("issue_id", x_issue_req_o.id, iv[i].id);
            check("issue_instr", x_issue_req_o.instr, iv[i].instr);
            check("issue_rs1", x_issue_req_o.rs[1], iv[i].instr ^ 32'h5a5a_0000);
            if (i == 0) check("commit_before_issue", x_commit_valid_o, 0);
            else check_commit(iv[i-1]);
            tick();
        end
        idle();
        settle();
        check_commit(iv[5]);
        tick();
        check("commit_pulse_end", x_commit_valid_o, 0);

        // Rejected issue: killed commit, nothing outstanding, busy drops
        do_reset();
        drive_issue(32'h0020_F053, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        settle();
        check("rej_commit_valid", x_commit_valid_o, 1);
        check("rej_commit_id", x_commit_o.id, 0);
        check("rej_commit_kill", x_commit_o.commit_kill, 1);
        check("rej_outstanding", dut.outstanding_q, 0);
        check("rej_busy_commit", busy_o, 1);
        tick();
        check("rej_busy_after", busy_o, 0);

        // ID wrap: 16 outstanding, 17th stalls on ID 0 until its result
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_issue(32'h1000 + i, 1'b1, 1'b1, 1'b0);
            tick();
        end
        settle();
        check("wrap_outstanding", dut.outstanding_q, 16'hFFFF);
        check("wrap_stall_valid", x_issue_valid_o, 0);
        check("wrap_stall_ready", instr_ready_o, 0);
        check("wrap_stall_id", x_issue_req_o.id, 0);
        tick();
        x_result_valid_i = 1;
        x_result_i = '{id: 4'd0, data: 32'h0, rd: 5'd1, we: 1'b0};
        settle();
        check("wrap_res_ready", x_result_ready_o, 1);
        check("wrap_same_cycle_stall", x_issue_valid_o, 0);
        tick();
        x_result_valid_i = 0;
        settle();
        check("wrap_resume_valid", x_issue_valid_o, 1);
        check("wrap_resume_outst", dut.outstanding_q, 16'hFFFE);
        check("wrap_no_wb", wb_valid_o, 0);
        tick();
        idle();
        settle();
        check("wrap_commit_valid", x_commit_valid_o, 1);
        check("wrap_commit_id", x_commit_o.id, 0);
        check("wrap_outst_full", dut.outstanding_q, 16'hFFFF);

        // Memory flow control, MEM_OUTSTANDING = 2, grant always high
        do_reset();
        data_gnt_i = 1;
        x_mem_valid_i = 1;
        x_mem_req_i = '{id: 4'd0, addr: 32'h0000_1000, we: 1'b0, wdata: 32'h0};
        settle();
        check("mem1_req", data_req_o, 1);
        check("mem1_ready", x_mem_ready_o, 1);
        check("mem1_addr", data_addr_o, 32'h0000_1000);
        tick();
        x_mem_req_i = '{id: 4'd1, addr: 32'h0000_1004, we: 1'b1, wdata: 32'hCAFE_0001};
        settle();
        check("mem2_req", data_req_o, 1);
        check("mem2_we", data_we_o, 1);
        check("mem2_wdata", data_wdata_o, 32'hCAFE_0001);
        tick();
        x_mem_req_i = '{id: 4'd2, addr: 32'h0000_1008, we: 1'b0, wdata: 32'h0};
        settle();
        check("mem3_blocked_req", data_req_o, 0);
        check("mem3_blocked_ready", x_mem_ready_o, 0);
        check("mem_busy", busy_o, 1);
        tick();
        data_rvalid_i = 1;
        data_rdata_i = 32'hDEAD_0000;
        settle();
        check("mem3_still_blocked", data_req_o, 0);
        tick();
        data_rvalid_i = 0;
        settle();
        check("memres0_valid", x_mem_result_valid_o, 1);
        check("memres0_rdata", x_mem_result_rdata_o, 32'hDEAD_0000);
        check("mem3_unblocked", data_req_o, 1);
        tick();
        x_mem_valid_i = 0;
        settle();
        check("memres_gap", x_mem_result_valid_o, 0);
        data_rvalid_i = 1;
        data_rdata_i = 32'h0000_0000;
        tick();
        data_rdata_i = 32'hBEEF_0002;
        settle();
        check("memres1_valid", x_mem_result_valid_o, 1);
        check("memres1_rdata", x_mem_result_rdata_o, 32'h0000_0000);
        tick();
        data_rvalid_i = 0;
        settle();
        check("memres2_valid", x_mem_result_valid_o, 1);
        check("memres2_rdata", x_mem_result_rdata_o, 32'hBEEF_0002);
        check("mem_idle_busy", busy_o, 0);
        check("mem_no_err", protocol_err_o, 0);
        tick();
        check("memres_end", x_mem_result_valid_o, 0);

        // Writeback back-pressure
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive_issue(32'h2000 + i, 1'b1, 1'b1, 1'b0);
            tick();
        end
        idle();
        tick();
        x_result_valid_i = 1;
        x_result_i = '{id: 4'd5, data: 32'h3F80_0000, rd: 5'd3, we: 1'b1};
        settle();
        check("wb_res_ready0", x_result_ready_o, 1);
        tick();
        x_result_i = '{id: 4'd0, data: 32'h0000_0011, rd: 5'd7, we: 1'b1};
        settle();
        check("wb_valid", wb_valid_o, 1);
        check("wb_rd", wb_rd_o, 3);
        check("wb_data", wb_data_o, 32'h3F80_0000);
        check("wb_outst", dut.outstanding_q, 16'h001F);
        check("wb_block", x_result_ready_o, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wb_hold_block", x_result_ready_o, 0);
            check("wb_hold_rd", wb_rd_o, 3);
        end
        wb_ready_i = 1;
        settle();
        check("wb_drain_ready", x_result_ready_o, 1);
        tick();
        x_result_valid_i = 0;
        wb_ready_i = 0;
        settle();
        check("wb2_valid", wb_valid_o, 1);
        check("wb2_rd", wb_rd_o, 7);
        check("wb2_data", wb_data_o, 32'h0000_0011);
        wb_ready_i = 1;
        tick();
        check("wb2_drained", wb_valid_o, 0);
        check("wb_outst2", dut.outstanding_q, 16'h001E);
        check("wb_no_err", protocol_err_o, 0);

        // Unknown-ID result: consumed without writeback, sticky error
        wb_ready_i = 0;
        x_result_valid_i = 1;
        x_result_i = '{id: 4'd9, data: 32'h1234_5678, rd: 5'd4, we: 1'b1};
        tick();
        x_result_valid_i = 0;
        settle();
        check("unk_no_wb", wb_valid_o, 0);
        check("unk_err", protocol_err_o, 1);
        tick(); tick(); tick();
        check("unk_err_sticky", protocol_err_o, 1);
        do_reset();
        check("unk_err_rst", protocol_err_o, 0);

        // Response with nothing outstanding
        data_rvalid_i = 1;
        data_rdata_i = 32'h0BAD_0BAD;
        tick();
        data_rvalid_i = 0;
        settle();
        check("stray_err", protocol_err_o, 1);
        check("stray_memres", x_mem_result_valid_o, 1);
        check("stray_busy", busy_o, 0);
        tick(); tick(); tick();
        check("stray_err_sticky", protocol_err_o, 1);
        do_reset();
        check("stray_err_rst", protocol_err_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu_ss_xif_initiator.md
# fpu_ss_xif_initiator

Core-side initiator for the eXtension interface driving the FPU subsystem.
- Accepts instructions from the core pipeline and issues them with sequential 4-bit IDs.
- Generates the matching commit transactions and services the coprocessor's memory requests against an OBI-style data port.
- Accepts results and returns writeback data to the core register file.
- Used in subsystem integration and as the core's offload front end.

## Interface
Parameters:
- NUM_ID, 16: ID space; power of two; ID width is log2(NUM_ID) = 4.
- MEM_OUTSTANDING, 2: maximum granted-but-unanswered data-port transactions.

Ports:
- Clock and reset are fixed: one clock; reset is asynchronous and active-low.
  - clk_i  in  1  clock.
  - rst_ni  in  1  asynchronous active-low reset.
- instr_valid_i / instr_ready_o  in/out  1  core instruction handshake.
- instr_i  in  32  instruction word.
- rs_i  in  3x32  source operands.
- rs_valid_i  in  3  operand valid.
- kill_i  in  1  kill request, sampled at issue handshake.
- x_issue_valid_o / x_issue_ready_i  out/in  1  issue handshake.
- x_issue_req_o  out  x_issue_req_t  {instr, id, rs, rs_valid}.
- x_issue_resp_accept_i, x_issue_resp_writeback_i  in  1  issue response.
- x_commit_valid_o  out  1  commit strobe.
- x_commit_o  out  x_commit_t  {id, commit_kill}.
- x_mem_valid_i / x_mem_ready_o  in/out  1  memory request handshake.
- x_mem_req_i  in  x_mem_req_t  {id, addr, we, wdata}.
- x_mem_result_valid_o  out  1  memory result strobe.
- x_mem_result_rdata_o  out  32  memory result data.
- data_req_o / data_gnt_i  out/in  1  data port request.
- data_addr_o, data_wdata_o  out  32  data port address and write data.
- data_we_o  out  1  data port write enable.
- data_rvalid_i  in  1  data port response valid.
- data_rdata_i  in  32  data port read data.
- x_result_valid_i / x_result_ready_o  in/out  1  result handshake.
- x_result_i  in  x_result_t  {id, data, rd, we}.
- wb_valid_o / wb_ready_i  out/in  1  register file writeback handshake.
- wb_rd_o  out  5  writeback destination register.
- wb_data_o  out  32  writeback data.
- busy_o  out  1  any activity in flight.
- protocol_err_o  out  1  sticky protocol error flag.

## Operation
Issue
- next_id register; increments on every issue handshake, wraps NUM_ID-1 -> 0.
- x_issue_valid_o = instr_valid_i & ~outstanding_q[next_id].
- instr_ready_o = x_issue_valid_o & x_issue_ready_i.
- x_issue_req_o carries instr_i, rs_i and rs_valid_i unmodified, with id = next_id.
- On handshake with accept=1, writeback=1 and no kill: set outstanding[next_id].
- Killed or non-accepted instructions never set outstanding.

Commit
- Every issue handshake produces exactly one commit for the same ID.
- commit_kill = ~accept | kill_i.

Results
- x_result_ready_o = ~wb_valid_o | wb_ready_i. The writeback register is a single entry.
- On result handshake: clear outstanding[id].
- If we=1, also load the writeback register with {rd, data}.
- A result whose ID is not outstanding is consumed without writeback and sets protocol_err_o.

Memory
- Counter cnt, range 0..MEM_OUTSTANDING; `space` means cnt < MEM_OUTSTANDING.
- data_req_o = x_mem_valid_i & space. addr, we and wdata pass through combinationally.
- x_mem_ready_o = data_gnt_i & space.
- cnt: +1 on grant, -1 on data_rvalid_i, unchanged when both occur in the same cycle.
- Every data_rvalid_i (stores included) produces one x_mem_result_valid_o, in order.
- data_rvalid_i while cnt==0 sets protocol_err_o; cnt does not go negative.

Status
- busy_o = |outstanding_q | x_commit_valid_o | (cnt!=0) | wb_valid_o.

## Timing
Reset values
- Every valid/strobe output, including x_commit_valid_o, x_mem_result_valid_o and wb_valid_o: 0.
- next_id, outstanding, cnt, protocol_err_o: 0.
- x_commit_o, wb_rd_o, wb_data_o, x_mem_result_rdata_o: 0.

Latencies
- Commit: registered; x_commit_valid_o is a one-cycle pulse in the cycle after the issue handshake. Back-to-back issues give back-to-back commits.
- Memory result: registered; x_mem_result_valid_o and rdata appear 1 cycle after data_rvalid_i.
- Writeback: wb_valid_o asserts the cycle after the result handshake and holds until wb_ready_i.

Hazards and boundaries
- Issue gating uses outstanding_q. A result clearing ID X in cycle N allows reissue of X in cycle N+1, not N.
- Set and clear of different IDs in the same cycle are independent.
- Wrap-around: reissue of a still-outstanding ID stalls issue.
- Asynchronous reset mid-transaction clears all state. In-flight commits and memory results are lost.

## Configuration
- FPU_SS_XIF_KILL_EN defined: kill_i is honoured as above.
- FPU_SS_XIF_KILL_EN undefined: kill_i is ignored and commit_kill = ~accept.

## Structure
- fpu_ss_pkg holds x_issue_req_t, x_commit_t (existing), x_mem_req_t, x_result_t, and the NUM_ID default constant.
- Sub-module fpu_ss_xif_mem_resp contains the memory counter, the data-port mapping and the result register.

## Test plan
- Reset, then 3 accepted FP adds with writeback. Required: IDs 0, 1, 2; commits in cycles N+1..N+3 with kill=0; outstanding = 0b111.
- Issue with accept=0. Required: commit id=0, commit_kill=1; outstanding stays 0; busy_o drops after the commit.
- Issue 16 instructions without results, then drive a 17th. Required: stall on ID 0. Return the result for ID 0; issue resumes one cycle later.
- Three memory requests, MEM_OUTSTANDING=2, gnt always 1. Required: third request blocked until rvalid; x_mem_result_valid_o one cycle after each rvalid, carrying the rdata.
- Result {id=5, rd=3, data=0x3F800000, we=1} with wb_ready_i=0 for 4 cycles. Required: x_result_ready_o=0 for a following result until writeback drains; wb_rd_o=3.
- Result for a non-outstanding ID, and rvalid with cnt==0. Required: protocol_err_o=1 and sticky until reset.
